frame_sender: RTL and testbench
===============================

FRAME_SENDER -- requirements
Module: frame_sender

Interface
REQ-001 Parameter NUM_BYTES, default 2, number of data bytes per frame, legal range 1..16.
REQ-002 Parameter GAP_CYCLES, default 2, idle clock cycles with ss high between frames, legal range 0..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 frame_data  input  NUM_BYTES*8  frame payload; byte k = frame_data[8k+7:8k].
REQ-006 frame_valid  input  1  frame_data is valid; the frame is held until accepted.
REQ-007 frame_ready  output  1  the block accepts a frame this cycle.
REQ-008 tx_data  output  8  byte presented to the SPI master, registered.
REQ-009 tx_start  output  1  one-cycle start pulse to the SPI master.
REQ-010 tx_ready  input  1  SPI master is idle.
REQ-011 tx_done  input  1  SPI master has finished the current byte, one-cycle pulse.
REQ-012 ss  output  1  slave select, active-low, registered.
REQ-013 frame_sent  output  1  one-cycle pulse when the last byte of a frame completes.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The state machine SHALL have three states: IDLE, SEND and GAP.
REQ-016 frame_ready SHALL equal (state==IDLE) & tx_ready & reset_n.
REQ-017 A frame SHALL be accepted on the edge where frame_valid & frame_ready; at that edge the block latches frame_data, sets ss=0, sets tx_start=1, loads tx_data with byte NUM_BYTES-1, clears the byte index and enters SEND.
REQ-018 Bytes SHALL be sent most-significant byte first (NUM_BYTES-1 down to 0).
REQ-019 tx_start SHALL be high for exactly one cycle per byte.
REQ-020 A tx_done that arrives in the same cycle as tx_start=1 SHALL be ignored.
REQ-021 In SEND, on tx_done for a byte that is not the last, the next edge SHALL load the next byte into tx_data and pulse tx_start, with ss held low.
REQ-022 In SEND, on tx_done for the last byte, the next edge SHALL set ss=1, pulse frame_sent and enter GAP, or enter IDLE if GAP_CYCLES==0.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles with ss=1, then the block enters IDLE.
REQ-024 frame_valid and frame_data SHALL be ignored outside IDLE; a later change to frame_data SHALL NOT alter the latched frame.
REQ-025 tx_data SHALL hold its value between start pulses and SHALL return to 8'h00 on entry to IDLE or GAP; it SHALL never be high-impedance.
REQ-026 Minimum frame period SHALL be (bytes per frame) SPI transfers + GAP_CYCLES + 1 cycles; back-to-back frames with continuously asserted frame_valid SHALL be supported.
REQ-027 The byte index width SHALL be $clog2(NUM_BYTES+1); index wrap SHALL NOT occur.

Reset
REQ-028 While reset_n=0, the block SHALL immediately force: state=IDLE, ss=1, tx_start=0, tx_data=8'h00, frame_sent=0, busy=0, frame_ready=0, byte index=0 and gap count=0.
REQ-029 A reset mid-frame SHALL abandon the frame with no frame_sent pulse; after release, the block waits for tx_ready before accepting a frame.

Configuration
REQ-030 Macro FRAME_SENDER_CHECKSUM_EN defined: after byte 0, one extra byte equal to the XOR of all NUM_BYTES data bytes SHALL be sent under the same ss-low window, and frame_sent follows that byte.
REQ-031 Macro FRAME_SENDER_CHECKSUM_EN undefined: exactly NUM_BYTES bytes per frame and no checksum logic.

Structure
REQ-032 Package frame_sender_pkg SHALL hold the state enum typedef (IDLE, SEND, GAP) and the constant BYTE_W=8.
REQ-033 The inter-frame gap counter SHALL be the sub-module frame_gap_timer (load, tick, expired).

Verification
REQ-034 NUM_BYTES=2, frame_data=16'h3F07, tx_ready=1, tx_done returned 10 cycles after each start -> tx_data 8'h3F then 8'h07, two tx_start pulses, ss low across both, one frame_sent.
REQ-035 GAP_CYCLES=2, frame_valid held high for two frames -> ss high for exactly 2 cycles between frames, with the second acceptance on the cycle after GAP ends.
REQ-036 tx_done pulsed in the same cycle as tx_start -> pulse ignored, and the byte advances only on the following tx_done.
REQ-037 reset_n low after the first tx_done of a 2-byte frame -> ss=1, tx_data=8'h00, tx_start=0 immediately, and no frame_sent pulse.
REQ-038 FRAME_SENDER_CHECKSUM_EN, NUM_BYTES=3, frame_data=24'h12_34_56 -> bytes 8'h12, 8'h34, 8'h56, 8'h70, with frame_sent after 8'h70.
REQ-039 tx_ready=0 with frame_valid=1 -> frame_ready=0 and no start; tx_ready=1 -> accepted on that edge.

Source files
------------

// File: rtl/frame_sender_pkg.sv
// Shared types and constants for the frame sender.
// Contents: state_e (IDLE/SEND/GAP), BYTE_W (SPI byte width), GAP_W (gap counter width).
package frame_sender_pkg;

  localparam int unsigned BYTE_W = 8;
  // Wide enough for the largest legal gap (255 cycles).
  localparam int unsigned GAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-frame gap down-counter.
// Ports:
//   clk        - clock
//   reset_n    - asynchronous active-low reset, clears the count
//   load       - load load_value into the counter
//   load_value - gap length in cycles
//   tick       - high for every cycle spent in the gap
//   expired    - high during the last gap cycle
module frame_gap_timer
  import frame_sender_pkg::*;
#(
  parameter int unsigned WIDTH = GAP_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // The count holds the number of gap cycles still to run, including this one.
  assign expired = tick && (count_q <= WIDTH'(1));

endmodule

// File: rtl/frame_sender.sv
// Frame sender: serialises a NUM_BYTES-wide frame, MSB first, to a byte-wide
// SPI master and frames it with an active-low slave select, followed by a
// GAP_CYCLES idle gap.
// Optional build macro FRAME_SENDER_CHECKSUM_EN appends an XOR checksum byte
// after byte 0 inside the same ss-low window.
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   frame_data, frame_valid  - frame payload and its valid (held until accepted)
//   frame_ready              - frame accepted this cycle when frame_valid is high
//   tx_data, tx_start        - byte and one-cycle start pulse to the SPI master
//   tx_ready, tx_done        - SPI master idle, byte-finished pulse
//   ss                       - slave select, active low
//   frame_sent               - pulse when the last byte of a frame completes
//   busy                     - high outside IDLE
module frame_sender
  import frame_sender_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_BYTES*BYTE_W-1:0] frame_data,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_ready,
  input  logic                        tx_done,
  output logic                        ss,
  output logic                        frame_sent,
  output logic                        busy
);

`ifdef FRAME_SENDER_CHECKSUM_EN
  localparam int unsigned TOTAL = NUM_BYTES + 1;
`else
  localparam int unsigned TOTAL = NUM_BYTES;
`endif
  localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);

  state_e                      state_q;
  logic [NUM_BYTES*BYTE_W-1:0] frame_q;
  logic [IDX_W-1:0]            idx_q;     // position of the byte in flight, 0 = first sent
  logic [IDX_W-1:0]            idx_next;
  logic [BYTE_W-1:0]           next_byte;
  logic                        done_ok;
  logic                        last_byte;
  logic                        gap_load;
  logic                        gap_tick;
  logic                        gap_expired;

  assign frame_ready = (state_q == IDLE) && tx_ready && reset_n;
  assign busy        = (state_q != IDLE);
  assign idx_next    = idx_q + IDX_W'(1);
  // A done arriving alongside our own start pulse belongs to nothing we sent.
  assign done_ok     = (state_q == SEND) && tx_done && !tx_start;
  assign last_byte   = (idx_q == IDX_W'(TOTAL - 1));

`ifdef FRAME_SENDER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      csum = csum ^ frame_q[k*BYTE_W +: BYTE_W];
    end
  end
`endif

  // Byte for position idx_next: data bytes MSB first, then the optional checksum.
  always_comb begin
    next_byte = '0;
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      if (idx_next == IDX_W'(int'(NUM_BYTES) - 1 - k)) begin
        next_byte = frame_q[k*BYTE_W +: BYTE_W];
      end
    end
`ifdef FRAME_SENDER_CHECKSUM_EN
    if (idx_next == IDX_W'(NUM_BYTES)) begin
      next_byte = csum;
    end
`endif
  end

  assign gap_load = done_ok && last_byte && (GAP_CYCLES != 0);
  assign gap_tick = (state_q == GAP);

  frame_gap_timer #(
    .WIDTH (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (gap_load),
    .load_value (GAP_W'(GAP_CYCLES)),
    .tick       (gap_tick),
    .expired    (gap_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      ss         <= 1'b1;
      frame_sent <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_sent <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_valid && frame_ready) begin
            frame_q  <= frame_data;
            tx_data  <= frame_data[(NUM_BYTES-1)*BYTE_W +: BYTE_W];
            tx_start <= 1'b1;
            ss       <= 1'b0;
            idx_q    <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (done_ok) begin
            if (last_byte) begin
              tx_data    <= '0;
              ss         <= 1'b1;
              frame_sent <= 1'b1;
              idx_q      <= '0;
              state_q    <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              tx_data  <= next_byte;
              tx_start <= 1'b1;
              idx_q    <= idx_next;
            end
          end
        end
        GAP: begin
          if (gap_expired) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sender.sv
module tb_frame_sender;

  localparam int NB  = 2;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB*8-1:0] frame_data = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready = 1'b0;
  logic          resp_done = 1'b0;
  logic          force_done = 1'b0;
  logic          tx_done;
  logic          ss;
  logic          frame_sent;
  logic          busy;

  assign tx_done = resp_done | force_done;

  frame_sender #(
    .NUM_BYTES  (NB),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .ss          (ss),
    .frame_sent  (frame_sent),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI master responder ----------------
  bit resp_en = 1'b1;
  int lat_min = 10;
  int lat_max = 10;
  int resp_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_done = 1'b0;
      if (!reset_n || !resp_en) begin
        resp_cnt = 0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) resp_done = 1'b1;
        end
        if (tx_start) resp_cnt = int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  // ---------------- Reference model and monitor ----------------
  int         m_phase = 0;  // 0 idle, 1 sending, 2 gap
  logic [7:0] m_q[$];
  logic [7:0] m_cur = '0;
  bit         m_start = 1'b0;
  bit         m_sent = 1'b0;
  int         m_gap = 0;
  logic [7:0] cap_q[$];
  int         sent_cnt = 0;

  initial begin
    bit         st;
    logic [7:0] x;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_phase = 0;
        m_q.delete();
        m_cur = '0;
        m_start = 1'b0;
        m_sent = 1'b0;
        m_gap = 0;
      end
      check("mdl frame_ready", 32'(frame_ready), 32'((m_phase == 0) && tx_ready && reset_n));
      check("mdl busy", 32'(busy), 32'(m_phase != 0));
      check("mdl ss", 32'(ss), 32'(m_phase != 1));
      check("mdl tx_start", 32'(tx_start), 32'(m_start));
      check("mdl tx_data", 32'(tx_data), 32'((m_phase == 1) ? m_cur : 8'h00));
      check("mdl frame_sent", 32'(frame_sent), 32'(m_sent));
      if (tx_start) cap_q.push_back(tx_data);
      if (frame_sent) sent_cnt++;
      if (reset_n) begin
        st = m_start;
        m_start = 1'b0;
        m_sent = 1'b0;
        case (m_phase)
          0: if (frame_valid && tx_ready) begin
            x = '0;
            for (int k = NB - 1; k >= 0; k--) begin
              m_q.push_back(frame_data[k*8 +: 8]);
              x = x ^ frame_data[k*8 +: 8];
            end
`ifdef FRAME_SENDER_CHECKSUM_EN
            m_q.push_back(x);
`endif
            m_cur = m_q.pop_front();
            m_start = 1'b1;
            m_phase = 1;
          end
          1: if (tx_done && !st) begin
            if (m_q.size() == 0) begin
              m_sent = 1'b1;
              m_cur = '0;
              m_gap = GAP;
              m_phase = (GAP == 0) ? 0 : 2;
            end else begin
              m_cur = m_q.pop_front();
              m_start = 1'b1;
            end
          end
          2: begin
            m_gap--;
            if (m_gap == 0) m_phase = 0;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- Helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_sent(input int max_cyc, input string name);
    int n = 0;
    while (!frame_sent && n < max_cyc) begin
      tick();
      n++;
    end
    check({name, " frame_sent timeout"}, 32'(frame_sent), 32'd1);
  endtask

  task automatic wait_for_byte(input logic [7:0] b, input int max_cyc, input string name);
    int n = 0;
    while (!(tx_start && tx_data == b) && n < max_cyc) begin
      tick();
      n++;
    end
    check({name, " start timeout"}, 32'(tx_start && tx_data == b), 32'd1);
  endtask

  typedef struct {
    logic rst;
    logic rdy;
    logic exp_ready;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   s0;
    int   gap_n;
    logic [7:0] exp_bytes[$];

    vecs[0] = '{rst: 1'b0, rdy: 1'b1, exp_ready: 1'b0};
    vecs[1] = '{rst: 1'b1, rdy: 1'b0, exp_ready: 1'b0};
    vecs[2] = '{rst: 1'b1, rdy: 1'b1, exp_ready: 1'b1};
    vecs[3] = '{rst: 1'b0, rdy: 1'b0, exp_ready: 1'b0};
    vecs[4] = '{rst: 1'b1, rdy: 1'b1, exp_ready: 1'b1};

    // Reset state
    tick();
    tick();
    check("rst ss", 32'(ss), 32'd1);
    check("rst tx_start", 32'(tx_start), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'h00);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_ready", 32'(frame_ready), 32'd0);
    check("rst frame_sent", 32'(frame_sent), 32'd0);

    // frame_ready truth table in IDLE (frame_valid low, so no acceptance)
    for (int i = 0; i < 5; i++) begin
      reset_n = vecs[i].rst;
      tx_ready = vecs[i].rdy;
      tick();
      check("tbl frame_ready", 32'(frame_ready), 32'(vecs[i].exp_ready));
      check("tbl busy", 32'(busy), 32'd0);
      check("tbl tx_start", 32'(tx_start), 32'd0);
    end

    // Single frame, done 10 cycles after each start; latched data survives input change
    cap_q.delete();
    s0 = sent_cnt;
    frame_data = 16'h3F07;
    frame_valid = 1'b1;
    tick();
    check("A first start", 32'(tx_start), 32'd1);
    check("A first byte", 32'(tx_data), 32'h3F);
    check("A ss low", 32'(ss), 32'd0);
    frame_valid = 1'b0;
    frame_data = 16'hAAAA;
    wait_for_sent(100, "A");
    check("A ss high at sent", 32'(ss), 32'd1);
    repeat (4) tick();
    exp_bytes = '{8'h3F, 8'h07};
`ifdef FRAME_SENDER_CHECKSUM_EN
    exp_bytes.push_back(8'h38);
`endif
    check("A byte count", 32'(cap_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < cap_q.size(); i++)
      check("A byte", 32'(cap_q[i]), 32'(exp_bytes[i]));
    check("A sent count", 32'(sent_cnt - s0), 32'd1);

    // Back-to-back frames with frame_valid held: gap length and re-acceptance
    lat_min = 3;
    lat_max = 3;
    cap_q.delete();
    frame_data = 16'h1234;
    frame_valid = 1'b1;
    tick();
    check("B first start", 32'(tx_start), 32'd1);
    frame_data = 16'h5678;
    wait_for_sent(100, "B1");
    gap_n = 0;
    while (busy && ss && gap_n < 20) begin
      gap_n++;
      tick();
    end
    check("B gap cycles", 32'(gap_n), 32'(GAP));
    check("B idle busy", 32'(busy), 32'd0);
    check("B idle ready", 32'(frame_ready), 32'd1);
    tick();
    check("B second start", 32'(tx_start), 32'd1);
    check("B second byte", 32'(tx_data), 32'h56);
    frame_valid = 1'b0;
    wait_for_sent(100, "B2");
    repeat (4) tick();
    exp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
`ifdef FRAME_SENDER_CHECKSUM_EN
    exp_bytes = '{8'h12, 8'h34, 8'h26, 8'h56, 8'h78, 8'h2E};
`endif
    check("B byte count", 32'(cap_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < cap_q.size(); i++)
      check("B byte", 32'(cap_q[i]), 32'(exp_bytes[i]));

    // tx_done coincident with tx_start is ignored
    resp_en = 1'b0;
    frame_data = 16'hC3A5;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    check("C start", 32'(tx_start), 32'd1);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("C no advance", 32'(tx_start), 32'd0);
    repeat (3) tick();
    check("C still idle start", 32'(tx_start), 32'd0);
    check("C hold byte", 32'(tx_data), 32'hC3);
    check("C ss low", 32'(ss), 32'd0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("C second start", 32'(tx_start), 32'd1);
    check("C second byte", 32'(tx_data), 32'hA5);
    tick();
`ifdef FRAME_SENDER_CHECKSUM_EN
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("C csum byte", 32'(tx_data), 32'h66);
    tick();
`endif
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("C frame_sent", 32'(frame_sent), 32'd1);
    resp_en = 1'b1;
    repeat (GAP + 2) tick();

    // Reset mid-frame, then wait for tx_ready before accepting
    frame_data = 16'hBEEF;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    wait_for_byte(8'hEF, 50, "D");
    s0 = sent_cnt;
    reset_n = 1'b0;
    #1;
    check("D rst ss", 32'(ss), 32'd1);
    check("D rst tx_data", 32'(tx_data), 32'h00);
    check("D rst tx_start", 32'(tx_start), 32'd0);
    check("D rst busy", 32'(busy), 32'd0);
    check("D rst frame_ready", 32'(frame_ready), 32'd0);
    tx_ready = 1'b0;
    frame_valid = 1'b1;
    frame_data = 16'h0102;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("D not ready", 32'(frame_ready), 32'd0);
      check("D no start", 32'(tx_start), 32'd0);
    end
    check("D no frame_sent", 32'(sent_cnt - s0), 32'd0);
    tx_ready = 1'b1;
    #1;
    check("D ready", 32'(frame_ready), 32'd1);
    tick();
    check("D accept start", 32'(tx_start), 32'd1);
    check("D accept byte", 32'(tx_data), 32'h01);
    frame_valid = 1'b0;
    wait_for_sent(100, "D");
    repeat (GAP + 2) tick();

    // Randomized traffic checked by the reference model each cycle
    lat_min = 1;
    lat_max = 6;
    s0 = sent_cnt;
    for (int i = 0; i < 1500; i++) begin
      frame_valid = ($urandom_range(0, 3) != 0);
      frame_data = NB'($urandom) * 0 + (NB*8)'($urandom);
      tx_ready = ($urandom_range(0, 4) != 0);
      if (i == 700) reset_n = 1'b0;
      if (i == 703) reset_n = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (60) tick();
    check("R frames sent", 32'(sent_cnt - s0 >= 20), 32'd1);
    check("R idle at end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
